// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver and transmitter on the host/debug
// link. It holds:
//   - the frame geometry (DATA_BITS)
//   - the default bit period in clocks (UART_CLKS_PER_BIT)
//   - the receiver state encoding (uart_state_t)
//   - a helper that sizes a counter for a given terminal count
// No ports: this is a package imported by the UART modules.
// -----------------------------------------------------------------------------
package uart_pkg;

  // Data bits per 8N1 frame, sent LSB first.
  localparam int DATA_BITS = 8;

  // Default clocks per bit, Fclk/baud. The transmitter uses the same value so
  // that both ends of the link agree.
  localparam int UART_CLKS_PER_BIT = 100;

  // Smallest bit period that still leaves room to find the middle of a bit
  // after the two synchroniser stages.
  localparam int UART_MIN_CLKS_PER_BIT = 8;

  // Receiver states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_t;

  // Width needed to hold the values 0..max_count.
  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser that brings asynchronous inputs into the clk domain.
// Each bit is synchronised on its own, so a multi-bit bus is only safe when the
// bits are mutually unrelated (for example separate status lines).
// Reset loads RST_VAL into both stages. For a UART line this is the idle level,
// so leaving reset never produces a false start bit.
// Ports:
//   clk  in        system clock
//   rst  in        asynchronous, active-high reset
//   i_d  in  WIDTH asynchronous input(s)
//   o_q  out WIDTH synchronised output(s), two clocks of latency
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_meta[gi] <= RST_VAL[gi];
        r_sync[gi] <= RST_VAL[gi];
      end else begin
        // r_meta may go metastable. It gets one full clock to resolve
        // before r_sync samples it.
        r_meta[gi] <= i_d[gi];
        r_sync[gi] <= r_meta[gi];
      end
    end
  end

  assign o_q = r_sync;

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver: 1 start bit, 8 data bits sent LSB first, 1 stop bit, no
// parity. It oversamples the rx line at clk and samples each bit near its
// middle. Each good byte is presented on data together with a one-cycle
// data_rdy strobe. A low stop bit raises a one-cycle frm_err strobe and leaves
// data unchanged.
// Parameters:
//   CLKS_PER_BIT  clocks per bit, Fclk/baud; must be >= 8
//   CNT_W         width of the bit-period counter; derived, do not override
// Ports:
//   clk       in      system clock; all logic runs on posedge
//   rst       in      asynchronous, active-high reset
//   rx        in      serial line; asynchronous to clk, idle high
//   data      out [8] last correctly received byte
//   data_rdy  out     one-cycle strobe: data was updated this cycle
//   frm_err   out     one-cycle strobe: the stop bit was sampled low
//   busy      out     high from start detection until the return to IDLE
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_rdy,
  output logic                 frm_err,
  output logic                 busy
);

  localparam int BIT_W = cnt_width(DATA_BITS - 1);

  // Terminal counts. The counter starts from 0, so "N clocks" ends at N-1.
  localparam logic [CNT_W-1:0] C_HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] C_FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] C_LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic                 w_rxs;
  uart_state_t          r_state;
  logic [CNT_W-1:0]     r_clk_cnt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_data_rdy;
  logic                 r_frm_err;
  logic                 r_busy;

  // The line idles high, so the synchroniser resets to 1. Leaving reset
  // therefore never looks like the falling edge of a start bit.
  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rx),
    .o_q (w_rxs)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_clk_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_data_rdy <= 1'b0;
      r_frm_err  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      // Both strobes default low, so each lasts exactly one cycle.
      r_data_rdy <= 1'b0;
      r_frm_err  <= 1'b0;

      unique case (r_state)
        ST_IDLE: begin
          r_clk_cnt <= '0;
          if (!w_rxs) begin
            r_state   <= ST_START;
            r_bit_cnt <= '0;
            r_busy    <= 1'b1;
          end
        end

        // Wait half a bit so that all later samples fall mid-bit. If the line
        // is high again at that point, the low pulse was too short to be a
        // start bit and is dropped.
        ST_START: begin
          if (r_clk_cnt >= C_HALF_M1) begin
            r_clk_cnt <= '0;
            if (w_rxs) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_DATA;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end

        // Shift in from the top. After eight samples the first bit received
        // (the LSB) has reached bit 0.
        ST_DATA: begin
          if (r_clk_cnt >= C_FULL_M1) begin
            r_clk_cnt <= '0;
            r_shift   <= {w_rxs, r_shift[DATA_BITS-1:1]};
            if (r_bit_cnt >= C_LAST_BIT) begin
              r_state <= ST_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end

        // Decide at mid stop bit and return to IDLE at once. The remaining
        // half bit is slack that absorbs baud mismatch when the next start
        // bit follows with no idle gap.
        ST_STOP: begin
          if (r_clk_cnt >= C_FULL_M1) begin
            r_clk_cnt <= '0;
            if (w_rxs) begin
              r_data     <= r_shift;
              r_data_rdy <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= ST_IDLE;
            end else begin
              r_frm_err <= 1'b1;
              r_state   <= ST_BREAK;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end

        // The line is still low after a bad stop bit, possibly a break.
        // Waiting here for the line to go high means a long break produces
        // only one frm_err instead of a stream of false frames.
        ST_BREAK: begin
          r_clk_cnt <= '0;
          if (w_rxs) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_clk_cnt <= '0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign data     = r_data;
  assign data_rdy = r_data_rdy;
  assign frm_err  = r_frm_err;
  assign busy     = r_busy;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB    = 16;
  localparam int CLK_NS = 10;
  localparam int BIT_NS = CPB * CLK_NS;
  // Bit periods about 2% off nominal, for mismatched-baud frames.
  localparam int SLOW_NS = 163;
  localparam int FAST_NS = 157;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       data_rdy;
  logic       frm_err;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .data_rdy (data_rdy),
    .frm_err  (frm_err),
    .busy     (busy)
  );

  always #(CLK_NS / 2) clk = ~clk;

  // Reference model: the ordered list of outcomes the line should produce
  // (one good byte or one framing error per frame), plus the byte that data
  // should be holding.
  typedef struct {
    bit         is_err;
    logic [7:0] val;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] model_data = 8'h00;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cycle    = 0;
  longint edge_cycle = 0;
  longint rdy_cycle  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor. It samples on the falling edge, away from the DUT's
  // active edge. Any strobe is matched against the next expected outcome;
  // a strobe with nothing expected is a spurious strobe.
  always @(negedge clk) begin : mon
    logic [1:0] obs_kind;
    logic [1:0] exp_kind;
    ev_t        ev;
    cycle++;
    if (!rst && (data_rdy || frm_err)) begin
      obs_kind = {frm_err, data_rdy};
      ev.is_err = 1'b0;
      ev.val    = 8'h00;
      exp_kind  = 2'b00;
      if (exp_q.size() > 0) begin
        ev = exp_q.pop_front();
        exp_kind = ev.is_err ? 2'b10 : 2'b01;
      end
      check_eq("strobe_kind", {30'd0, obs_kind}, {30'd0, exp_kind});
      if (exp_kind == 2'b01) begin
        model_data = ev.val;
        rdy_cycle  = cycle;
        check_eq("rx_byte", {24'd0, data}, {24'd0, ev.val});
      end
    end
  end

  // Ideal serialiser: start bit, 8 data bits LSB first, then the stop bit.
  // With a low stop bit, rx is left low on return.
  task automatic send_byte(input logic [7:0] b, input bit stop_val, input int p_ns);
    edge_cycle = cycle;
    rx = 1'b0;
    #(p_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(p_ns);
    end
    rx = stop_val;
    #(p_ns);
  endtask

  task automatic push_ev(input bit is_err, input logic [7:0] v);
    ev_t e;
    e.is_err = is_err;
    e.val    = v;
    exp_q.push_back(e);
  endtask

  // Bounded wait for every expected outcome to have been seen.
  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", exp_q.size(), 0);
    repeat (CPB) @(negedge clk);
  endtask

  initial begin
    longint lat;

    // Test 1: reset, then the line left idle.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_data", {24'd0, data}, 32'h00);
    check_eq("rst_rdy", {31'd0, data_rdy}, 32'd0);
    check_eq("rst_err", {31'd0, frm_err}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    repeat (1000) @(negedge clk);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);
    $display("txn reset/idle: 1000 clk with rx high");

    // Test 2: a single good frame and its latency.
    @(posedge clk); #1;
    push_ev(1'b0, 8'hA5);
    send_byte(8'hA5, 1'b1, BIT_NS);
    wait_drain();
    lat = rdy_cycle - edge_cycle;
    check_eq("latency_window", {31'd0, (lat >= 150 && lat <= 158)}, 32'd1);
    check_eq("a5_data", {24'd0, data}, {24'd0, model_data});
    check_eq("a5_busy", {31'd0, busy}, 32'd0);
    $display("txn frame A5: latency %0d clk", lat);

    // Test 3: a 5-clock low glitch.
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1 rx = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("glitch_busy", {31'd0, busy}, 32'd0);
    check_eq("glitch_data", {24'd0, data}, 32'hA5);
    $display("txn glitch: 5 clk low pulse");

    // Test 4: a low stop bit, then the line held low for 40 bit times in all.
    @(posedge clk); #1;
    push_ev(1'b1, 8'h00);
    send_byte(8'h00, 1'b0, BIT_NS);
    #(30 * BIT_NS);
    @(negedge clk);
    check_eq("break_busy_hi", {31'd0, busy}, 32'd1);
    check_eq("break_data", {24'd0, data}, 32'hA5);
    check_eq("break_errs", exp_q.size(), 0);
    #1 rx = 1'b1;
    repeat (8) @(negedge clk);
    check_eq("break_busy_lo", {31'd0, busy}, 32'd0);
    wait_drain();
    $display("txn break: frame 00 with low stop bit, line low 40 bit times");

    // Test 5: back-to-back frames, no idle gap, with mismatched bit periods.
    @(posedge clk); #1;
    push_ev(1'b0, 8'h55);
    push_ev(1'b0, 8'hAA);
    send_byte(8'h55, 1'b1, FAST_NS);
    send_byte(8'hAA, 1'b1, SLOW_NS);
    wait_drain();
    check_eq("b2b_data", {24'd0, data}, 32'hAA);
    $display("txn back-to-back: 55 @%0dns/bit, AA @%0dns/bit", FAST_NS, SLOW_NS);

    // Test 6: reset asserted during bit 4 of 8'hFF, then a clean frame.
    @(posedge clk); #1;
    rx = 1'b0;
    #(BIT_NS);
    rx = 1'b1;
    #(4 * BIT_NS + BIT_NS / 2);
    rst = 1'b1;
    exp_q.delete();
    model_data = 8'h00;
    #(2 * CLK_NS);
    rst = 1'b0;
    #(4 * BIT_NS);
    @(negedge clk);
    check_eq("midrst_data", {24'd0, data}, 32'h00);
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    push_ev(1'b0, 8'h3C);
    send_byte(8'h3C, 1'b1, BIT_NS);
    wait_drain();
    check_eq("after_rst_data", {24'd0, data}, 32'h3C);
    $display("txn mid-frame reset then frame 3C");

    // Randomised traffic: good frames (one or two back-to-back), framing
    // errors with a break of random length, and short glitches.
    for (int t = 0; t < 24; t++) begin
      int kind;
      int p;
      logic [7:0] b;
      kind = $urandom_range(0, 9);
      @(posedge clk); #1;
      if (kind == 0) begin
        b = 8'($urandom);
        p = $urandom_range(FAST_NS, SLOW_NS);
        push_ev(1'b1, 8'h00);
        send_byte(b, 1'b0, p);
        #($urandom_range(0, 20) * BIT_NS);
        rx = 1'b1;
        wait_drain();
        check_eq("rnd_err_busy", {31'd0, busy}, 32'd0);
        $display("txn %0d: framing error, byte %02h, %0d ns/bit", t, b, p);
      end else if (kind == 1) begin
        int g;
        g = $urandom_range(1, 5);
        rx = 1'b0;
        repeat (g) @(posedge clk);
        #1 rx = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("rnd_glitch_busy", {31'd0, busy}, 32'd0);
        $display("txn %0d: glitch %0d clk", t, g);
      end else begin
        int nfr;
        nfr = $urandom_range(1, 2);
        for (int f = 0; f < nfr; f++) begin
          b = 8'($urandom);
          p = $urandom_range(FAST_NS, SLOW_NS);
          push_ev(1'b0, b);
          send_byte(b, 1'b1, p);
          $display("txn %0d.%0d: frame %02h, %0d ns/bit", t, f, b, p);
        end
        wait_drain();
      end
      check_eq("rnd_data_hold", {24'd0, data}, {24'd0, model_data});
      repeat ($urandom_range(0, 2) * CPB) @(posedge clk);
    end

    repeat (50) @(negedge clk);
    check_eq("final_pending", exp_q.size(), 0);
    check_eq("final_data", {24'd0, data}, {24'd0, model_data});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_uart_rx
